fir_post_decim: RTL

//  Output conditioning stage placed directly after the 40-tap FIR (fir40_min).
//  - Takes one 32-bit signed FIR result per strobe and keeps one sample in DECIM.
//  - Rounds, shifts and saturates each kept sample to DOUT_W bits.
//  - Buffers results in a small FIFO and delivers them over a valid/ready interface to the display path.

---
 rtl/fir_post_decim.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/fir_post_decim.sv
// Output conditioning after the 40-tap FIR: decimate, round/shift, saturate,
// then buffer in a show-ahead FIFO drained over a valid/ready handshake.
module fir_post_decim #(
   parameter int DIN_W      = 32,
   parameter int DOUT_W     = 16,
   parameter int SHIFT      = 15,
   parameter int DECIM      = 4,
   parameter int FIFO_DEPTH = 8
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          clr,
   input  logic                          din_en,
   input  logic [DIN_W-1:0]              din,
   output logic [DOUT_W-1:0]             dout,
   output logic                          dout_valid,
   input  logic                          dout_ready,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
   output logic                          sat_flag,
   output logic                          ovf_flag
);

   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam int LVL_W = PTR_W + 1;
   localparam int PH_W  = (DECIM > 1) ? $clog2(DECIM) : 1;

   localparam logic signed [DIN_W:0] RND   = (DIN_W+1)'(64'sd1 <<< (SHIFT-1));
   localparam logic signed [DIN_W:0] MAX_S = (DIN_W+1)'((64'sd1 <<< (DOUT_W-1)) - 64'sd1);
   localparam logic signed [DIN_W:0] MIN_S = (DIN_W+1)'(-(64'sd1 <<< (DOUT_W-1)));
   localparam logic [DOUT_W-1:0]     MAX_Q = {1'b0, {(DOUT_W-1){1'b1}}};
   localparam logic [DOUT_W-1:0]     MIN_Q = {1'b1, {(DOUT_W-1){1'b0}}};
   localparam logic [PH_W-1:0]       PH_LAST = PH_W'(DECIM-1);

   logic [PH_W-1:0]          phase_q, phase_d;
   logic                     keep_w;
   logic                     in_v_q;
   logic [DIN_W-1:0]         in_q, in_d;
   logic                     s1_v_q;
   logic signed [DIN_W:0]    s1_q, s1_d;
   logic                     s2_v_q;
   logic [DOUT_W-1:0]        s2_q, s2_d;
   logic                     s2_sat;

   logic [DOUT_W-1:0]        mem [FIFO_DEPTH];
   logic [PTR_W-1:0]         wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]         rd_ptr_q, rd_ptr_d;
   logic [LVL_W-1:0]         level_q, level_d;
   logic [DOUT_W-1:0]        dout_q, dout_d;
   logic                     sat_q, ovf_q;
   logic                     full, pop, push, drop;

   // Decimation: only the sample accepted at phase 0 enters the pipeline.
   always_comb begin
      phase_d = phase_q;
      keep_w  = 1'b0;
      in_d    = in_q;
      if (din_en) begin
         keep_w  = (phase_q == '0);
         phase_d = (phase_q == PH_LAST) ? '0 : phase_q + 1'b1;
         if (keep_w) begin
            in_d = din;
         end
      end
   end

   // Sign-extend by one bit so adding the rounding constant cannot overflow.
   always_comb begin
      s1_d = ($signed({in_q[DIN_W-1], in_q}) + RND) >>> SHIFT;
   end

   always_comb begin
      s2_sat = 1'b0;
      s2_d   = s1_q[DOUT_W-1:0];
      if (s1_q > MAX_S) begin
         s2_d   = MAX_Q;
         s2_sat = 1'b1;
      end else if (s1_q < MIN_S) begin
         s2_d   = MIN_Q;
         s2_sat = 1'b1;
      end
   end

   assign full = (level_q == LVL_W'(FIFO_DEPTH));
   assign pop  = (level_q != '0) && dout_ready && !clr;
   assign push = s2_v_q && !clr && (!full || pop);
   assign drop = s2_v_q && !clr && full && !pop;

   // dout is registered show-ahead: predict the head after this edge,
   // bypassing the word being written when it lands at the new read slot.
   always_comb begin
      wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
      rd_ptr_d = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
      level_d  = level_q + LVL_W'(push) - LVL_W'(pop);
      dout_d   = dout_q;
      if (level_d != '0) begin
         if (push && (wr_ptr_q == rd_ptr_d)) begin
            dout_d = s2_q;
         end else begin
            dout_d = mem[rd_ptr_d];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_ptr_q] <= s2_q;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         phase_q  <= '0;
         in_v_q   <= 1'b0;
         in_q     <= '0;
         s1_v_q   <= 1'b0;
         s1_q     <= '0;
         s2_v_q   <= 1'b0;
         s2_q     <= '0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         level_q  <= '0;
         dout_q   <= '0;
         sat_q    <= 1'b0;
         ovf_q    <= 1'b0;
      end else if (clr) begin
         phase_q  <= '0;
         in_v_q   <= 1'b0;
         in_q     <= '0;
         s1_v_q   <= 1'b0;
         s1_q     <= '0;
         s2_v_q   <= 1'b0;
         s2_q     <= '0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         level_q  <= '0;
         dout_q   <= '0;
         sat_q    <= 1'b0;
         ovf_q    <= 1'b0;
      end else begin
         phase_q  <= phase_d;
         in_v_q   <= keep_w;
         in_q     <= in_d;
         s1_v_q   <= in_v_q;
         s1_q     <= s1_d;
         s2_v_q   <= s1_v_q;
         s2_q     <= s2_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         level_q  <= level_d;
         dout_q   <= dout_d;
         sat_q    <= sat_q | (s1_v_q & s2_sat);
         ovf_q    <= ovf_q | drop;
      end
   end

   assign dout       = dout_q;
   assign dout_valid = (level_q != '0);
   assign fifo_level = level_q;
   assign sat_flag   = sat_q;
   assign ovf_flag   = ovf_q;

endmodule
